noc_inject_arbiter: RTL
=======================

// Module: noc_inject_arbiter
// PURPOSE
//  Shares the single NoC injection port among NUM_REQ flit sources (CPU flitizer, system/config source, ...).
//  Round-robin, packet-atomic: once a source wins, it keeps the port until its tail flit (req_last) is accepted.
//  Output is registered through a 2-entry skid buffer, so out_* is timing-clean toward the router input.
//  Guards against a non-terminating packet with a per-packet flit counter, forced release and sticky error.
// PARAMETERS
//  NUM_REQ        2   number of requesters (>=2)
//  MAX_PKT_FLITS  16  max flits per packet; counter width $clog2(MAX_PKT_FLITS+1)
//  SRC_W          $clog2(NUM_REQ)  width of source index (derived, localparam)
// PORTS
//  nocclk         in   1                 clock
//  rst_n          in   1                 reset, asynchronous, active-low
//  req_flit       in   NUM_REQ x flit_t  flit from each requester
//  req_valid      in   NUM_REQ           requester i presents a flit
//  req_last       in   NUM_REQ           flit of requester i is the packet tail
//  req_ready      out  NUM_REQ           flit of requester i accepted this edge if valid&ready
//  out_flit       out  flit_t            flit toward router injection port
//  out_valid      out  1                 out_flit valid
//  out_last       out  1                 out_flit is packet tail
//  out_src        out  SRC_W             index of requester that sent out_flit
//  out_ready      in   1                 router accepts out_flit if valid&ready
//  err_pkt_overrun out 1                 sticky: a packet exceeded MAX_PKT_FLITS; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, owner=0, flit_cnt=0, skid empty; out_valid=0, out_last=0, out_src=0,
//   out_flit=0, req_ready=0, err_pkt_overrun=0. Async reset mid-packet discards skid contents and lock.
//  FSM IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ); combinational.
//   req_ready[winner] = buf_in_ready; all others 0. No valid requester -> all req_ready 0.
//   accept & req_last  -> stay IDLE, rr_ptr <= winner+1 (mod NUM_REQ).
//   accept & !req_last -> LOCKED, owner <= winner, flit_cnt <= 1.
//  FSM LOCKED: req_ready[owner] = buf_in_ready; all others 0 regardless of their valid.
//   Owner dropping req_valid mid-packet is legal: port stays locked (no timeout).
//   accept & req_last  -> IDLE, rr_ptr <= owner+1, flit_cnt <= 0.
//   accept & !req_last & flit_cnt==MAX_PKT_FLITS-1 -> forced release: flit forwarded with out_last=1,
//     err_pkt_overrun <= 1, IDLE, rr_ptr <= owner+1. Subsequent owner flits arbitrate as a new packet.
//   else accept -> flit_cnt <= flit_cnt+1.
//  Wrap: rr_ptr = NUM_REQ-1 advances to 0; NUM_REQ not power of 2 handled by explicit compare, not truncation.
//  Skid buffer: buf_in_ready = !skid_full (registered, not combinational from out_ready).
//   Latency: flit accepted at edge k -> out_valid=1 with that flit in cycle after edge k (1 cycle) when empty.
//   out_valid & !out_ready: out_flit/out_last/out_src held stable; second accepted flit parked in skid entry.
//   Simultaneous out handshake and input accept with both entries in use: order preserved, no loss/duplication.
//   Throughput: 1 flit/cycle sustained while out_ready=1.
//  out_src records accepting requester index per flit (travels with flit through skid).
//  Flit contents forwarded unmodified (checksum already generated upstream).
// STRUCTURE
//  types package: add noc_src_id_t sized for max sources; flit_t reused unchanged.
//  Local enum {IDLE, LOCKED} stays in this module.
//  Sub-module flit_skid_buffer #(W) : 2-entry valid/ready register slice, payload {flit_t, last, src}.
//  Arbiter + FSM + counter in this module; round-robin search as a for-loop priority from rr_ptr.
// TESTING
//  1 Single source: req0 sends 3-flit pkt (last on 3rd), out_ready=1 -> out_valid cycles 2..4, out_src=0, out_last only on 3rd.
//  2 Contention: req0,req1 both 2-flit pkts, valid from cycle 1 -> out order r0,r0,r1,r1; req_ready[1]=0 while r0 locked.
//  3 Fairness: both sources stream 1-flit pkts forever -> out_src alternates 0,1,0,1 for 20 flits.
//  4 Backpressure: out_ready=0 for 5 cycles mid-pkt -> out_flit stable, exactly 2 flits buffered, req_ready=0 after; release -> no loss/dup.
//  5 Overrun: MAX_PKT_FLITS=4, req0 sends 6 flits, never last -> 4th flit out_last=1, err_pkt_overrun=1 sticky; req1 pending gets next grant.
//  6 Reset mid-pkt: assert rst_n=0 after 2nd of 4 flits -> out_valid=0, req_ready=0 immediately; after release IDLE, rr_ptr=0, new pkt from req1 passes.

Source files
------------

// File: rtl/noc_inject_arbiter_pkg.sv
// Shared NoC injection types.
// Flit payload, source ids and small index helpers.
package noc_inject_arbiter_pkg;

  localparam int FLIT_W      = 32;
  localparam int NOC_MAX_SRC = 16;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [$clog2(NOC_MAX_SRC)-1:0] noc_src_id_t;

  // Explicit compare so non power-of-2 counts wrap correctly.
  function automatic int wrap_inc(input int i, input int n);
    return (i >= n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_skid.sv
// Two-entry valid/ready register slice.
// Input ready is registered so it never depends on out_ready.
module flit_skid_buffer #(
  parameter int W = 8
) (
  input  logic         nocclk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         rdy_q, rdy_d;
  logic         push, pop;

  assign push = in_valid & rdy_q;
  assign pop  = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || pop) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = push;
        if (push) main_d = in_data;
      end
    end else if (push) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = main_q;
  assign out_valid = main_vld_q;

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter for the NoC injection port.
// Locks to a source until its tail; forces release on overrun.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter  int NUM_REQ       = 2,
  parameter  int MAX_PKT_FLITS = 16,
  localparam int SRC_W         = $clog2(NUM_REQ)
) (
  input  logic               nocclk,
  input  logic               rst_n,
  input  flit_t              req_flit [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] req_ready,
  output flit_t              out_flit,
  output logic               out_valid,
  output logic               out_last,
  output logic [SRC_W-1:0]   out_src,
  input  logic               out_ready,
  output logic               err_pkt_overrun
);

  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);
  localparam int W     = FLIT_W + 1 + SRC_W;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
  logic             err_q, err_d;

  logic [SRC_W-1:0] win_idx, sel;
  logic             win_found, grant;
  logic             accept, cnt_max, fwd_last;
  logic             buf_in_ready, buf_in_valid;
  logic [W-1:0]     buf_in, buf_out;

  // Two passes: lowest index overall, then lowest at/after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && j >= int'(rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(j);
      end
    end
  end

  assign sel          = (state_q == LOCKED) ? owner_q : win_idx;
  assign grant        = (state_q == LOCKED) | win_found;
  assign buf_in_valid = grant & req_valid[sel];
  assign accept       = buf_in_valid & buf_in_ready;
  assign cnt_max      = (state_q == LOCKED) &&
                        (flit_cnt_q == CNT_W'(MAX_PKT_FLITS - 1));
  assign fwd_last     = req_last[sel] | cnt_max;
  assign buf_in       = {req_flit[sel], fwd_last, sel};

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      flit_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      flit_cnt_q <= flit_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    flit_cnt_d = flit_cnt_q;
    err_d      = err_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (req_last[sel]) begin
            rr_ptr_d = SRC_W'(wrap_inc(int'(sel), NUM_REQ));
          end else begin
            state_d    = LOCKED;
            owner_d    = sel;
            flit_cnt_d = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (req_last[sel] || cnt_max) begin
            state_d    = IDLE;
            rr_ptr_d   = SRC_W'(wrap_inc(int'(sel), NUM_REQ));
            flit_cnt_d = '0;
            if (!req_last[sel]) err_d = 1'b1;
          end else begin
            flit_cnt_d = flit_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[sel] = buf_in_ready;
  end

  flit_skid_buffer #(
    .W (W)
  ) u_skid (
    .nocclk    (nocclk),
    .rst_n     (rst_n),
    .in_data   (buf_in),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_flit        = buf_out[W-1 -: FLIT_W];
  assign out_last        = buf_out[SRC_W];
  assign out_src         = buf_out[SRC_W-1:0];
  assign err_pkt_overrun = err_q;

endmodule
